addsub_chunk_sequencer: RTL and testbench

- Control stage wrapped around the team's combinational 7-bit carry-look-ahead adder stage.
- Accepts ALU add/subtract operations over a valid/ready handshake and drives the adder's A, B and carry-in.
- Captures the adder result, derives C/V/Z/N flags (the adder has no carry-out), and returns the result over a second valid/ready handshake.
- Supports a 14-bit wide mode: two sequential 7-bit passes with the carry chained between them.

---
 rtl/addsub_chunk_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_addsub_chunk_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_chunk_sequencer.sv
// rtl/addsub_chunk_sequencer.sv - add/subtract sequencer around a 7-bit combinational adder chunk
//
// Purpose:
//   Accepts ALU add/subtract style operations over a valid/ready handshake,
//   feeds an external combinational CHUNK_W-bit adder one chunk per cycle,
//   captures its sum, derives C/V/Z/N flags and returns the result over a
//   second valid/ready handshake. Wide mode runs two chained chunk passes
//   (low then high) with the chunk carry fed into the second pass.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operation request handshake
//   in_op                 000 ADD, 001 ADC, 010 SUB, 011 SBC,
//                         100 INC, 101 DEC, 110 CMP, 111 PASS
//   in_wide               1 = 2*CHUNK_W-bit operation, 0 = CHUNK_W-bit
//   in_a, in_b            operands (narrow uses the low chunk only)
//   in_cflag              carry flag consumed by ADC/SBC
//   add_a, add_b, add_cin chunk operands to the adder (add_b already inverted
//                         for subtracting ops)
//   add_r                 adder sum, combinational from add_a/add_b/add_cin
//   out_valid/out_ready   result handshake
//   out_result            result
//   out_c/out_v/out_z/out_n carry, signed overflow, zero, negative
//   busy                  high whenever the sequencer is not idle
//
// Optional feature macro: ADDSUB_SAT_EN
//   When defined, ADD/ADC/SUB/SBC results that overflow clamp to the signed
//   limit of the active width; flags still describe the unclamped sum.

module addsub_chunk_sequencer #(
  parameter int CHUNK_W         = 7,
  parameter bit SIGN_EXT_NARROW = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic                   in_wide,
  input  logic [2*CHUNK_W-1:0]   in_a,
  input  logic [2*CHUNK_W-1:0]   in_b,
  input  logic                   in_cflag,
  output logic [CHUNK_W-1:0]     add_a,
  output logic [CHUNK_W-1:0]     add_b,
  output logic                   add_cin,
  input  logic [CHUNK_W-1:0]     add_r,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*CHUNK_W-1:0]   out_result,
  output logic                   out_c,
  output logic                   out_v,
  output logic                   out_z,
  output logic                   out_n,
  output logic                   busy
);

  localparam int WIDE_W = 2 * CHUNK_W;
  localparam int MSB    = CHUNK_W - 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBC  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_CMP  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;

  // Operation context latched at the accept edge.
  logic [2:0]          op_q;
  logic                wide_q;
  logic [WIDE_W-1:0]   a_q;
  logic [WIDE_W-1:0]   b_q;      // post-mapping B (inverted / forced)
  logic [CHUNK_W-1:0]  lo_q;     // low chunk sum from the LO pass

  logic                accept;

  // Operand mapping of the incoming request.
  logic [WIDE_W-1:0]   map_b;
  logic                map_cin;

  // Chunk carry analysis of the current adder pass.
  logic                carry_in_msb;
  logic                chunk_carry;

  // Final result / flags, valid in the last pass (LO narrow or HI wide).
  logic [CHUNK_W-1:0]  narrow_val;
  logic [WIDE_W-1:0]   wide_val;
  logic [WIDE_W-1:0]   fin_result;
  logic                fin_c;
  logic                fin_v;
  logic                fin_z;
  logic                fin_n;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    map_b   = in_b;
    map_cin = 1'b0;
    case (in_op)
      OP_ADD: begin
        map_b   = in_b;
        map_cin = 1'b0;
      end
      OP_ADC: begin
        map_b   = in_b;
        map_cin = in_cflag;
      end
      OP_SUB, OP_CMP: begin
        map_b   = ~in_b;
        map_cin = 1'b1;
      end
      OP_SBC: begin
        map_b   = ~in_b;
        map_cin = in_cflag;
      end
      OP_INC: begin
        map_b   = '0;
        map_cin = 1'b1;
      end
      OP_DEC: begin
        map_b   = '1;
        map_cin = 1'b0;
      end
      default: begin  // OP_PASS
        map_b   = '0;
        map_cin = 1'b0;
      end
    endcase
  end

  // The adder exposes no carry-out. The carry into the chunk MSB is
  // recovered from the sum bit, and the carry out follows from the MSB
  // generate/propagate terms.
  assign carry_in_msb = add_r[MSB] ^ add_a[MSB] ^ add_b[MSB];
  assign chunk_carry  = (add_a[MSB] & add_b[MSB]) |
                        ((add_a[MSB] ^ add_b[MSB]) & carry_in_msb);

  always_comb begin
    fin_c = chunk_carry;
    fin_v = carry_in_msb ^ chunk_carry;
    fin_n = add_r[MSB];
    fin_z = (add_r == '0) && (!wide_q || (lo_q == '0));

    // CMP only produces flags; its result is operand A untouched.
    if (op_q == OP_CMP) begin
      narrow_val = a_q[CHUNK_W-1:0];
      wide_val   = a_q;
    end else begin
      narrow_val = add_r;
      wide_val   = {add_r, lo_q};
    end

`ifdef ADDSUB_SAT_EN
    // Only the two-operand arithmetic ops clamp. A set sign bit on an
    // overflowing sum means the true result was positive.
    if ((op_q[2] == 1'b0) && fin_v) begin
      if (fin_n) begin
        narrow_val = {1'b0, {(CHUNK_W-1){1'b1}}};
        wide_val   = {1'b0, {(WIDE_W-1){1'b1}}};
      end else begin
        narrow_val = {1'b1, {(CHUNK_W-1){1'b0}}};
        wide_val   = {1'b1, {(WIDE_W-1){1'b0}}};
      end
    end
`endif

    if (wide_q) begin
      fin_result = wide_val;
    end else begin
      fin_result = {{CHUNK_W{SIGN_EXT_NARROW & narrow_val[MSB]}}, narrow_val};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_ADD;
      wide_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      lo_q       <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_cin    <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_c      <= 1'b0;
      out_v      <= 1'b0;
      out_z      <= 1'b0;
      out_n      <= 1'b0;
    end else if (accept) begin
      // Accept happens from IDLE or from DONE while the result is taken.
      state     <= LO;
      op_q      <= in_op;
      wide_q    <= in_wide;
      a_q       <= in_a;
      b_q       <= map_b;
      add_a     <= in_a[CHUNK_W-1:0];
      add_b     <= map_b[CHUNK_W-1:0];
      add_cin   <= map_cin;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        LO: begin
          if (wide_q) begin
            state   <= HI;
            lo_q    <= add_r;
            add_a   <= a_q[WIDE_W-1:CHUNK_W];
            add_b   <= b_q[WIDE_W-1:CHUNK_W];
            add_cin <= chunk_carry;
          end else begin
            state      <= DONE;
            add_a      <= '0;
            add_b      <= '0;
            add_cin    <= 1'b0;
            out_valid  <= 1'b1;
            out_result <= fin_result;
            out_c      <= fin_c;
            out_v      <= fin_v;
            out_z      <= fin_z;
            out_n      <= fin_n;
          end
        end
        HI: begin
          state      <= DONE;
          add_a      <= '0;
          add_b      <= '0;
          add_cin    <= 1'b0;
          out_valid  <= 1'b1;
          out_result <= fin_result;
          out_c      <= fin_c;
          out_v      <= fin_v;
          out_z      <= fin_z;
          out_n      <= fin_n;
        end
        DONE: begin
          // Result and flags hold until the consumer takes them.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_chunk_sequencer.sv
// tb/tb_addsub_chunk_sequencer.sv - scoreboard bench for addsub_chunk_sequencer

module tb_addsub_chunk_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_wide;
  logic [13:0] in_a;
  logic [13:0] in_b;
  logic        in_cflag;
  logic [6:0]  add_a;
  logic [6:0]  add_b;
  logic        add_cin;
  logic [6:0]  add_r;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_result;
  logic        out_c;
  logic        out_v;
  logic        out_z;
  logic        out_n;
  logic        busy;

  typedef struct {
    logic [13:0] r;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

`ifdef ADDSUB_SAT_EN
  localparam logic [13:0] EXP_N_OVF = 14'h003F;
  localparam logic [13:0] EXP_W_OVF = 14'h2000;
`else
  localparam logic [13:0] EXP_N_OVF = 14'h0040;
  localparam logic [13:0] EXP_W_OVF = 14'h1FFF;
`endif

  // Team 7-bit adder stage model
  assign add_r = 7'(add_a + add_b + {6'b0, add_cin});

  addsub_chunk_sequencer #(
    .CHUNK_W         (7),
    .SIGN_EXT_NARROW (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_wide    (in_wide),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_cflag   (in_cflag),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_r      (add_r),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_c      (out_c),
    .out_v      (out_v),
    .out_z      (out_z),
    .out_n      (out_n),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [13:0] r, input logic c, input logic v,
                              input logic z, input logic n);
    exp_t e;
    e.r = r; e.c = c; e.v = v; e.z = z; e.n = n;
    return e;
  endfunction

  // Monitor: every result handed over is compared with the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {13'b0, out_valid}, 14'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", out_result, e.r);
        chk("flag_c", {13'b0, out_c}, {13'b0, e.c});
        chk("flag_v", {13'b0, out_v}, {13'b0, e.v});
        chk("flag_z", {13'b0, out_z}, {13'b0, e.z});
        chk("flag_n", {13'b0, out_n}, {13'b0, e.n});
      end
    end
  end

  // Presents a request, waits for acceptance, returns just after the accept
  // edge (sequencer in LO) with the inputs scrambled to prove latching.
  task automatic issue(input logic [2:0] op, input logic w, input logic [13:0] a,
                       input logic [13:0] b, input logic cf, input exp_t e,
                       input bit push);
    int n;
    n = 0;
    in_op = op; in_wide = w; in_a = a; in_b = b; in_cflag = cf; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 14'h0, 14'h1);
      in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op = 3'b101; in_a = '1; in_b = '1; in_cflag = 1'b1; in_wide = ~w;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_queue_empty", 14'(exp_q.size()), 14'h0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_wide = 1'b0;
    in_a = '0; in_b = '0; in_cflag = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {13'b0, out_valid}, 14'h0);
    chk("rst_in_ready", {13'b0, in_ready}, 14'h1);
    chk("rst_busy", {13'b0, busy}, 14'h0);
    chk("rst_add_a", {7'b0, add_a}, 14'h0);
    chk("rst_add_cin", {13'b0, add_cin}, 14'h0);
    chk("rst_result", out_result, 14'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Narrow ADD with latency and drive checks
    issue(3'b000, 1'b0, 14'h0025, 14'h001A, 1'b0, mk(14'h003F, 0, 0, 0, 0), 1);
    chk("add_lo_cin", {13'b0, add_cin}, 14'h0);
    chk("add_lo_a", {7'b0, add_a}, 14'h0025);
    chk("add_lo_in_ready", {13'b0, in_ready}, 14'h0);
    chk("add_lo_no_valid", {13'b0, out_valid}, 14'h0);
    @(posedge clk); #1;
    chk("add_valid_1edge", {13'b0, out_valid}, 14'h1);

    // Narrow SUB equal operands
    issue(3'b010, 1'b0, 14'h0010, 14'h0010, 1'b0, mk(14'h0000, 1, 0, 1, 0), 1);
    chk("sub_add_b", {7'b0, add_b}, 14'h006F);
    chk("sub_add_cin", {13'b0, add_cin}, 14'h1);

    // CMP, INC wrap, ADC, SBC
    issue(3'b110, 1'b0, 14'h0005, 14'h0009, 1'b0, mk(14'h0005, 0, 0, 0, 1), 1);
    issue(3'b100, 1'b0, 14'h007F, 14'h0000, 1'b0, mk(14'h0000, 1, 0, 1, 0), 1);
    issue(3'b001, 1'b0, 14'h0010, 14'h0020, 1'b1, mk(14'h0031, 0, 0, 0, 0), 1);
    issue(3'b011, 1'b0, 14'h0010, 14'h0005, 1'b0, mk(14'h000A, 1, 0, 0, 0), 1);
    drain();

    // Wide ADD with carry chained into the high pass
    issue(3'b000, 1'b1, 14'h007F, 14'h0001, 1'b0, mk(14'h0080, 0, 0, 0, 0), 1);
    chk("wide_lo_add_r", {7'b0, add_r}, 14'h0000);
    @(posedge clk); #1;
    chk("wide_hi_cin", {13'b0, add_cin}, 14'h1);
    chk("wide_hi_no_valid", {13'b0, out_valid}, 14'h0);
    @(posedge clk); #1;
    chk("wide_valid_2edge", {13'b0, out_valid}, 14'h1);

    // Narrow overflow, wide DEC/SUB overflow/PASS/wrap to zero
    issue(3'b000, 1'b0, 14'h003F, 14'h0001, 1'b0, mk(EXP_N_OVF, 0, 1, 0, 1), 1);
    issue(3'b101, 1'b1, 14'h0000, 14'h0000, 1'b0, mk(14'h3FFF, 0, 0, 0, 1), 1);
    issue(3'b010, 1'b1, 14'h2000, 14'h0001, 1'b0, mk(EXP_W_OVF, 1, 1, 0, 0), 1);
    issue(3'b111, 1'b1, 14'h1234, 14'h0FFF, 1'b0, mk(14'h1234, 0, 0, 0, 0), 1);
    issue(3'b000, 1'b1, 14'h3FFF, 14'h0001, 1'b0, mk(14'h0000, 1, 0, 1, 0), 1);
    drain();

    // Backpressure: result held in DONE, then same-cycle handover
    out_ready = 1'b0;
    issue(3'b000, 1'b0, 14'h0025, 14'h001A, 1'b0, mk(14'h003F, 0, 0, 0, 0), 1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", {13'b0, out_valid}, 14'h1);
      chk("bp_result_held", out_result, 14'h003F);
      chk("bp_in_ready_low", {13'b0, in_ready}, 14'h0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(3'b010, 1'b0, 14'h0009, 14'h0005, 1'b0, mk(14'h0004, 1, 0, 0, 0), 1);
    chk("bp_handover_busy", {13'b0, busy}, 14'h1);
    chk("bp_handover_valid_low", {13'b0, out_valid}, 14'h0);
    drain();

    // Reset during HI of a wide op
    issue(3'b000, 1'b1, 14'h1111, 14'h0222, 1'b0, mk(14'h0, 0, 0, 0, 0), 0);
    @(posedge clk); #1;
    chk("abort_busy_hi", {13'b0, busy}, 14'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {13'b0, out_valid}, 14'h0);
    chk("abort_add_a", {7'b0, add_a}, 14'h0);
    chk("abort_add_b", {7'b0, add_b}, 14'h0);
    chk("abort_add_cin", {13'b0, add_cin}, 14'h0);
    chk("abort_busy", {13'b0, busy}, 14'h0);
    chk("abort_in_ready", {13'b0, in_ready}, 14'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_stays_idle", {13'b0, busy}, 14'h0);
    chk("abort_no_valid", {13'b0, out_valid}, 14'h0);

    // Recovery after abort
    issue(3'b000, 1'b0, 14'h0001, 14'h0002, 1'b0, mk(14'h0003, 0, 0, 0, 0), 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
